// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a single-ported data memory: splits misaligned accesses
// into two word transactions, aligns store lanes, merges and extends load bytes.
module mem_access_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] reqAddr,
    input  logic [1:0]  reqOp,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqWdata,
    output logic        respValid,
    output logic [31:0] respRdata,
    output logic        respErr,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memBe,
    input  logic        memAck,
    input  logic [31:0] memRdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);
    localparam logic [1:0] OP_NOP      = 2'b00;
    localparam logic [1:0] OP_LOAD     = 2'b01;
    localparam logic [1:0] OP_STORE    = 2'b10;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf0;
    logic [31:0] r_buf1;
    logic [1:0]  r_op;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_err;
    logic [7:0]  r_waitCnt;

    logic        w_illegal;
    logic [7:0]  w_sizeMask;
    logic [7:0]  w_laneMask;
    logic        w_split;
    logic [63:0] w_wdataWide;
    logic [63:0] w_rdataWide;
    logic [31:0] w_loadData;

    assign w_illegal = (reqOp == 2'b11) || (reqSize == 2'b11);

    always_comb begin
        case (r_size)
            2'b00:   w_sizeMask = 8'h01;
            2'b01:   w_sizeMask = 8'h03;
            default: w_sizeMask = 8'h0F;
        endcase
    end

    // Lanes 7:4 of the shifted mask belong to the second word; any set bit there means a split.
    assign w_laneMask  = w_sizeMask << r_addr[1:0];
    assign w_split     = |w_laneMask[7:4];
    assign w_wdataWide = {32'd0, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_rdataWide = {r_buf1, r_buf0} >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_loadData = r_unsigned ? {24'd0, w_rdataWide[7:0]}
                                             : {{24{w_rdataWide[7]}}, w_rdataWide[7:0]};
            2'b01:   w_loadData = r_unsigned ? {16'd0, w_rdataWide[15:0]}
                                             : {{16{w_rdataWide[15]}}, w_rdataWide[15:0]};
            default: w_loadData = w_rdataWide[31:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_op       <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_waitCnt  <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (reqValid) begin
                        r_addr     <= reqAddr;
                        r_wdata    <= reqWdata;
                        r_op       <= reqOp;
                        r_size     <= reqSize;
                        r_unsigned <= reqUnsigned;
                        r_err      <= w_illegal;
                        r_waitCnt  <= '0;
                    end
                end
                ACC0, ACC1: begin
                    if (memAck) begin
                        if (r_state == ACC0) r_buf0 <= memRdata;
                        else                 r_buf1 <= memRdata;
                        r_waitCnt <= '0;
                    end else if (r_waitCnt == LP_MAX_WAIT) begin
                        r_err <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nextState = r_state;
        reqReady    = 1'b0;
        respValid   = 1'b0;
        respRdata   = '0;
        respErr     = 1'b0;
        memReq      = 1'b0;
        memWe       = 1'b0;
        memAddr     = '0;
        memWdata    = '0;
        memBe       = '0;
        case (r_state)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    if (w_illegal || reqOp == OP_NOP) w_nextState = RESP;
                    else                              w_nextState = ACC0;
                end
            end
            ACC0: begin
                memReq   = 1'b1;
                memWe    = (r_op == OP_STORE);
                memAddr  = {r_addr[31:2], 2'b00};
                memBe    = w_laneMask[3:0];
                memWdata = w_wdataWide[31:0];
                if (memAck)                         w_nextState = w_split ? ACC1 : RESP;
                else if (r_waitCnt == LP_MAX_WAIT)  w_nextState = RESP;
            end
            ACC1: begin
                memReq   = 1'b1;
                memWe    = (r_op == OP_STORE);
                memAddr  = {r_addr[31:2] + 30'd1, 2'b00};
                memBe    = w_laneMask[7:4];
                memWdata = w_wdataWide[63:32];
                if (memAck || r_waitCnt == LP_MAX_WAIT) w_nextState = RESP;
            end
            RESP: begin
                respValid   = 1'b1;
                respErr     = r_err;
                respRdata   = (!r_err && r_op == OP_LOAD) ? w_loadData : 32'd0;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a byte-level model predicts every memory
// transaction and response, cycle by cycle, with a small MAX_WAIT to reach timeouts.
module tb_mem_access_ctrl;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [31:0] reqAddr = '0;
    logic [1:0]  reqOp = '0;
    logic [1:0]  reqSize = '0;
    logic        reqUnsigned = 1'b0;
    logic [31:0] reqWdata = '0;
    logic        respValid;
    logic [31:0] respRdata;
    logic        respErr;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = '0;

    int errCount = 0;
    int checkCount = 0;

    mem_access_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqOp(reqOp),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqWdata(reqWdata),
        .respValid(respValid), .respRdata(respRdata), .respErr(respErr),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memBe(memBe), .memAck(memAck), .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".reqReady"}, reqReady, 1);
        checkOutput({tag, ".respValid"}, respValid, 0);
        checkOutput({tag, ".memReq"}, memReq, 0);
        checkOutput({tag, ".memBe"}, memBe, 0);
        checkOutput({tag, ".memAddr"}, memAddr, 0);
        checkOutput({tag, ".respRdata"}, respRdata, 0);
    endtask

    // Caller is at a negedge with the DUT idle; dly >= MAXW+1 means memory never acks.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rd0, input logic [31:0] rd1,
                                 input int dly0, input int dly1);
        logic [3:0]  expBe [2];
        logic [31:0] expWd [2];
        logic [31:0] mask;
        logic [63:0] both;
        logic [31:0] expLoad;
        logic        illegal;
        logic        timedOut;
        int          n, off, nAcc, dly;

        illegal  = (op == 2'b11) || (size == 2'b11);
        n        = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off      = int'(addr[1:0]);
        nAcc     = (off + n > 4) ? 2 : 1;
        expBe[0] = '0; expBe[1] = '0;
        expWd[0] = '0; expWd[1] = '0;
        for (int i = 0; i < n; i++) begin
            expBe[(off + i) / 4][(off + i) % 4] = 1'b1;
            expWd[(off + i) / 4][8 * ((off + i) % 4) +: 8] = wdata[8 * i +: 8];
        end
        both    = {rd1, rd0};
        expLoad = '0;
        for (int i = 0; i < n; i++) expLoad[8 * i +: 8] = both[8 * (off + i) +: 8];
        for (int j = n; j < 4; j++) expLoad[8 * j +: 8] = (!uns && expLoad[8 * n - 1]) ? 8'hFF : 8'h00;

        checkOutput("reqReady", reqReady, 1);
        reqValid = 1'b1; reqOp = op; reqSize = size; reqUnsigned = uns;
        reqAddr = addr; reqWdata = wdata;
        @(negedge clk);
        reqValid = 1'b0; reqAddr = $urandom; reqWdata = $urandom;

        if (illegal || op == 2'b00) begin
            checkOutput("short.memReq", memReq, 0);
            checkOutput("short.respValid", respValid, 1);
            checkOutput("short.respErr", respErr, illegal);
            checkOutput("short.respRdata", respRdata, 0);
            @(negedge clk);
            return;
        end

        timedOut = 1'b0;
        for (int k = 0; k < nAcc; k++) begin
            dly = (k == 0) ? dly0 : dly1;
            for (int i = 0; i < 4; i++) mask[8 * i +: 8] = {8{expBe[k][i]}};
            for (int c = 0; c <= MAXW; c++) begin
                checkOutput("acc.memReq", memReq, 1);
                checkOutput("acc.respValid", respValid, 0);
                checkOutput("acc.reqReady", reqReady, 0);
                checkOutput("acc.memWe", memWe, op == 2'b10);
                checkOutput("acc.memAddr", memAddr, {addr[31:2], 2'b00} + 32'(4 * k));
                checkOutput("acc.memBe", memBe, expBe[k]);
                checkOutput("acc.memWdata", memWdata & mask, expWd[k]);
                if (c == dly) begin
                    memAck = 1'b1;
                    memRdata = (k == 0) ? rd0 : rd1;
                    @(negedge clk);
                    memAck = 1'b0;
                    memRdata = $urandom;
                    break;
                end
                @(negedge clk);
                if (c == MAXW) timedOut = 1'b1;
            end
            if (timedOut) break;
        end

        checkOutput("resp.respValid", respValid, 1);
        checkOutput("resp.respErr", respErr, timedOut);
        checkOutput("resp.memReq", memReq, 0);
        checkOutput("resp.respRdata", respRdata, (timedOut || op != 2'b01) ? 32'd0 : expLoad);
        @(negedge clk);

        if (timedOut) begin
            memAck = 1'b1;
            checkIdleOutputs("lateAck");
            @(negedge clk);
            memAck = 1'b0;
            checkIdleOutputs("afterLateAck");
        end
    endtask

    task automatic resetInAcc1();
        checkOutput("rst.reqReady", reqReady, 1);
        reqValid = 1'b1; reqOp = 2'b01; reqSize = 2'b10; reqUnsigned = 1'b0;
        reqAddr = 32'h0000_1002; reqWdata = '0;
        @(negedge clk);
        reqValid = 1'b0;
        memAck = 1'b1; memRdata = 32'hAABB_CCDD;
        @(negedge clk);
        memAck = 1'b0;
        checkOutput("rst.acc1Addr", memAddr, 32'h0000_1004);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("rstAsserted");
        checkOutput("rstAsserted.respErr", respErr, 0);
        checkOutput("rstAsserted.memWe", memWe, 0);
        checkOutput("rstAsserted.memWdata", memWdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkIdleOutputs("rstReleased");
    endtask

    initial begin
        logic [1:0] op, size;
        int r, d0, d1;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset.respErr", respErr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(2'b01, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0);
        applyStimulus(2'b01, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h8011_2233, 32'h0, 0, 0);
        applyStimulus(2'b01, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h8011_2233, 32'h0, 0, 0);
        applyStimulus(2'b01, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, 0);
        applyStimulus(2'b10, 2'b01, 1'b0, 32'h0000_2003, 32'h0000_BEEF, 32'h0, 32'h0, 0, 0);
        applyStimulus(2'b01, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 100, 100);
        applyStimulus(2'b01, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h1234_5678, 32'h0, 2, 100);
        applyStimulus(2'b11, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 32'h0, 0, 0);
        applyStimulus(2'b01, 2'b11, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 32'h0, 0, 0);
        applyStimulus(2'b00, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 32'h0, 0, 0);
        applyStimulus(2'b01, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h7F00_0000, 32'h0000_00FF, 3, 1);
        resetInAcc1();

        $display("[TB] random cases");
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            op = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r < 6) ? 2'b01 : 2'b10;
            size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            d0 = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, MAXW - 1);
            d1 = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, MAXW - 1);
            applyStimulus(op, size, 1'($urandom_range(0, 1)), $urandom, $urandom,
                          $urandom, $urandom, d0, d1);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer between the pipeline's memory stage and the single-ported data memory. It accepts one load or store request at a time and issues one or two word-aligned memory transactions, splitting misaligned accesses. Load bytes are extracted, merged and sign/zero-extended before a single response is returned. It replaces the pass-through read path in the memory stage and supplies the byte enables, data alignment and timeout detection that path lacks.

## Interface
- MAX_WAIT, 255: cycles one memory transaction may wait for `memAck` before aborting with error; must be 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  controller can accept a request.
- reqAddr  in  32  byte address.
- reqOp  in  2  00 no-op, 01 load, 10 store, 11 illegal.
- reqSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
- reqUnsigned  in  1  1 zero-extends loads, 0 sign-extends loads.
- reqWdata  in  32  store data, right-justified.
- respValid  out  1  one-cycle response pulse; there is no backpressure.
- respRdata  out  32  extended load data; 0 for stores, no-ops and errors.
- respErr  out  1  qualified by respValid; set for an illegal op/size or a timeout.
- memReq  out  1  memory transaction request.
- memWe  out  1  1 for write, 0 for read.
- memAddr  out  32  word-aligned address; bits [1:0] are always 0.
- memWdata  out  32  write data, lane-aligned.
- memBe  out  4  byte enables; bit i selects bits [8i+7:8i].
- memAck  in  1  transaction complete; read data is valid in the same cycle.
- memRdata  in  32  read data.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- Reset values: state IDLE; reqReady 1; all other outputs 0; wait counter 0.

IDLE
- reqReady is 1 only in IDLE.
- On `reqValid` at an edge, latch the request.
- Illegal op or size: go to RESP with err=1.
- No-op: go to RESP with err=0.
- Load or store: go to ACC0.

Lane computation
- off = addr[1:0]; n = 1/2/4 bytes.
- split = (off + n > 4).
- ACC0: address addr & ~3, lanes off..min(3, off+n-1).
- ACC1: address (addr & ~3)+4, lanes 0..(off+n-5).
- Store data: reqWdata shifted left by 8*off. ACC0 drives the low 32 bits and ACC1 the bits shifted out above bit 31.
- Loads drive memBe with the same lanes; memory ignores it on reads.

ACC0 / ACC1
- memReq=1; memAddr, memWe, memBe and memWdata are held constant until memAck.
- memAck is ignored when memReq=0.
- On memAck in ACC0: capture memRdata into buffer 0; go to ACC1 if split, otherwise RESP.
- On memAck in ACC1: capture into buffer 1; go to RESP.
- The wait counter clears on entry to each ACC state and increments each cycle without ack. When it equals MAX_WAIT, go to RESP with err=1 and drop memReq; a later memAck is ignored.

RESP
- respValid=1 for one cycle, then IDLE.
- Load data: take the 64-bit value {buf1, buf0} >> 8*off, then the low n bytes, then extend per reqUnsigned.
- Error responses force respRdata to 0.

## Timing
- A request accepted at edge t drives memReq during cycle t+1.
- An unsplit access with memAck in its first cycle gives respValid during cycle t+2 and reqReady=1 again in cycle t+3.
- Each additional wait cycle or the split access adds one cycle per cycle or access.
- Illegal op/size and no-op requests give respValid at t+1.
- Timeout: respValid comes MAX_WAIT+1 cycles after the ACC state is entered.
- rst_n asserted mid-transaction immediately drops memReq and respValid and returns to IDLE. No response is produced for the aborted request.

## Test plan
- Aligned word load at 0x1000, memRdata 0xDEADBEEF with ack in the first cycle -> one transaction with memBe 1111; respRdata 0xDEADBEEF at t+2.
- Byte load at 0x1003, memRdata 0x80112233 -> respRdata 0xFFFFFF80 signed; 0x00000080 with reqUnsigned=1.
- Word load at 0x1002; first access 0x1000 returns 0xAABBCCDD, second 0x1004 returns 0x11223344 -> respRdata 0x3344AABB.
- Half store 0xBEEF at 0x2003 -> access 0x2000 with memBe 1000, memWdata 0xEF000000; then 0x2004 with memBe 0001, memWdata 0x000000BE; respRdata 0.
- memAck never asserted, MAX_WAIT=4 -> respErr=1 five cycles after ACC0 entry; memReq low afterwards; a late ack causes no state change.
- reqOp 11 -> respErr at t+1 with no memReq. A separate case drops rst_n during ACC1 -> all outputs at reset values and reqReady=1.
